sha256_pad_1024: RTL and testbench
==================================

# sha256_pad_1024

Message formatter ahead of `sha256_1024in`: accepts a byte message (password + salt) as a stream of big-endian 32-bit words and performs standard SHA-256 padding (0x80 marker, zero fill, 64-bit bit-length). It emits one 1024-bit (two SHA block) word through a valid/ready handshake that connects directly to the hasher's `in`/`in_valid`/`in_ready`. It is the initiator side of that interface and is used by the PBKDF2 wrapper and by benches as a replacement for hand-padded traces.

## Interface
- `MAX_BYTES_P`, default 119: largest message length accepted; fixed by the 1024-bit block minus 9 pad/length bytes.
- `MIN_BYTES_P`, default 56: smallest length whose padding needs two blocks.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `in` in 32: message word; byte 0 is in bits 31:24.
- `in_valid` in 1: `in` is valid.
- `in_last` in 1: qualifies the final word of the message.
- `in_bytes` in 2: valid bytes in the last word; 0 means 4. Ignored when `in_last` is 0.
- `in_ready` out 1: the formatter accepts a word this cycle.
- `out` out 1024: padded block; message byte 0 is in bits 1023:1016.
- `out_valid` out 1: `out` holds a complete padded block.
- `out_ready` in 1: consumer takes `out`.
- `err_o` out 1: one-cycle pulse when a message is dropped (only with `SHA256_PAD_ERR_EN`).

## Operation
- **States:** ACCUM, HOLD, DROP.
- **Reset values:** state ACCUM, word counter 0, buffer all-zero, `out_valid`=0, `err_o`=0. `in_ready`=0 while `rst_i` is high.
- **ACCUM**
  - `in_ready`=1.
  - On accept (`in_valid & in_ready`), word k (k = counter, 0..29) is written to `out[1023-32k -: 32]`.
  - The counter is 5 bits and increments per accepted non-last word.
- **Last word accepted** (counter k, byte count b = 1..4 after the 0→4 mapping):
  - Byte count L = 4k + b.
  - Invalid bytes of the word are written as 0.
  - 0x80 is written at byte L.
  - `out[63:0]` = 8·L, zero-extended to 64 bits.
  - All other buffer bytes remain 0.
  - Next state HOLD.
- **HOLD**
  - `out_valid`=1, `in_ready`=0, `out` stable.
  - On `out_valid & out_ready`: buffer cleared, counter set to 0, state ACCUM.
- **Length error:** L < `MIN_BYTES_P`, or a non-last word is accepted with counter = 29 (the message would exceed 119 bytes).
  - With `SHA256_PAD_ERR_EN`: `err_o` pulses one cycle. If the last word was already seen, go to ACCUM with the buffer cleared. Otherwise go to DROP.
- **DROP:** `in_ready`=1; words are discarded until the `in_last` word, then ACCUM with the buffer cleared.
- **Async reset mid-message:** the partial message is lost; no output is produced for it.

## Timing
- Latency: last word accepted on edge N → `out_valid`=1 after edge N (visible in cycle N+1).
- Throughput: one block per (words + 1) cycles minimum. The HOLD→ACCUM transition costs one cycle in which `in_ready`=0.
- `in_ready` and `out_valid` are registered and never high in the same cycle.
- `out` must not change while `out_valid`=1, regardless of `in_valid`.
- `out_ready` high with `out_valid` low has no effect.
- `err_o` is registered and asserts the cycle after the offending accept.

## Configuration
- `SHA256_PAD_ERR_EN`
  - Defined: length checks, the DROP state and `err_o` are implemented as described under Operation.
  - Undefined:
    - No checks; `err_o` tied to 0.
    - Words beyond index 29 are ignored but still accepted.
    - Short messages are padded as-is. This gives a non-standard, still deterministic block: 0x80 at byte L, length in bits 63:0.

## Structure
- Package `sha256_pkg` holds:
  - `SHA_BLOCK2_W` = 1024.
  - `SHA_LEN_W` = 64.
  - The `pad_state_e` enum (ACCUM, HOLD, DROP).
  - `PAD_MARKER` = 8'h80.
- One sub-module, `sha256_pad_byte_lane`: a combinational per-word mask/marker insert. Given the word, `in_bytes` and `in_last`, it produces the masked word plus a marker-spill flag for when b = 4, in which case the marker goes in the next word.

## Test plan
- **64-byte message:** 16 × 0x61616161, last `in_bytes`=0 → `out[1023:512]` all 0x61, `out[511:504]`=0x80, `out[63:0]`=0x200, latency 1 cycle.
- **56-byte message** (14 words) → `out[575:568]`=0x80, `out[63:0]`=0x1C0, bytes between are zero.
- **119-byte message** (30 words, last `in_bytes`=3) → `out[71:64]`=0x80, `out[63:0]`=0x3B8.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` → `out` stable, `in_ready`=0; release → ACCUM next cycle, second message padded independently with no residue from the first.
- **Length error** (`SHA256_PAD_ERR_EN`): 20-byte message → `err_o` pulses once, `out_valid` stays 0. A 31-word stream → DROP until last, then a following 64-byte message produces the correct block.
- **Reset mid-message:** assert `rst_i` after 7 words → `out_valid`=0 and `in_ready`=0 during reset; a fresh 64-byte message afterwards produces the expected block.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths, marker byte and formatter state encoding
package sha256_pkg;
  localparam int SHA_BLOCK2_W = 1024;
  localparam int SHA_LEN_W = 64;
  localparam logic [7:0] PAD_MARKER = 8'h80;
  typedef enum logic [1:0] {ACCUM = 2'd0, HOLD = 2'd1, DROP = 2'd2} pad_state_e;
endpackage

// File: rtl/sha256_pad_byte_lane.sv
// sha256_pad_byte_lane: masks invalid bytes of the last word and inserts the 0x80 marker, flagging a spill into the next word
module sha256_pad_byte_lane
  import sha256_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  bytes_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic [2:0]  nbytes_o,
  output logic        spill_o
);
  // keep valid bytes, marker right after them, zeros beyond; a full last word pushes the marker out
  always_comb begin
    nbytes_o = (bytes_i == 2'd0) ? 3'd4 : {1'b0, bytes_i};
    spill_o = last_i & (bytes_i == 2'd0);
    word_o = word_i;
    for (int j = 0; j < 4; j++)
      if (last_i) word_o[31-8*j -: 8] = (3'(j) < nbytes_o) ? word_i[31-8*j -: 8] : (3'(j) == nbytes_o ? PAD_MARKER : 8'h00);
  end
endmodule

// File: rtl/sha256_pad_1024.sv
// sha256_pad_1024: packs a word stream into one SHA-256 padded 1024-bit block; SHA256_PAD_ERR_EN enables length checks, DROP and err_o
module sha256_pad_1024
  import sha256_pkg::*;
#(
  parameter int MAX_BYTES_P = 119,
  parameter int MIN_BYTES_P = 56
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [31:0]             in,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [1:0]              in_bytes,
  output logic                    in_ready,
  output logic [SHA_BLOCK2_W-1:0] out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_o
);
  localparam int NW = (MAX_BYTES_P + 1) / 4;
`ifdef SHA256_PAD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  pad_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [SHA_BLOCK2_W-1:0] buf_q, buf_d;
  logic ready_q, valid_q, err_q, err_d;
  logic [31:0] lane_word;
  logic [2:0] nbytes;
  logic spill, accept, too_short, too_long, len_err;
  logic [6:0] len;
  sha256_pad_byte_lane u_lane (
    .word_i  (in),
    .bytes_i (in_bytes),
    .last_i  (in_last),
    .word_o  (lane_word),
    .nbytes_o(nbytes),
    .spill_o (spill)
  );
  assign accept = in_valid & ready_q;
  assign len = {cnt_q, 2'b00} + 7'(nbytes);
  assign too_short = len < 7'(MIN_BYTES_P);
  assign too_long = cnt_q == 5'(NW - 1);
  assign len_err = ERR_EN && state_q == ACCUM && accept && (in_last ? too_short : too_long);
  assign in_ready = ready_q;
  assign out_valid = valid_q;
  assign out = buf_q;
  assign err_o = err_q;
  // next state: accumulate words, finish padding on the last one, hold until taken, or discard on length errors
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    err_d = len_err;
    if (state_q == HOLD) begin
      if (out_ready) begin
        state_d = ACCUM;
        cnt_d = '0;
        buf_d = '0;
      end
    end else if (state_q == DROP) begin
      if (accept && in_last) state_d = ACCUM;
    end else if (len_err) begin
      state_d = in_last ? ACCUM : DROP;
      cnt_d = '0;
      buf_d = '0;
    end else if (accept) begin
      for (int i = 0; i < NW; i++) begin
        if (cnt_q == 5'(i)) buf_d[SHA_BLOCK2_W-1-32*i -: 32] = lane_word;
        if (spill && i > 0 && cnt_q == 5'(i - 1)) buf_d[SHA_BLOCK2_W-1-32*i -: 8] = PAD_MARKER;
      end
      if (in_last) begin
        buf_d[SHA_LEN_W-1:0] = SHA_LEN_W'({len, 3'b000});
        state_d = HOLD;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 5'(cnt_q != 5'(NW));
      end
    end
  end
  // state registers; handshake flags are registered from the next state so they never overlap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      cnt_q <= '0;
      buf_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      ready_q <= state_d != HOLD;
      valid_q <= state_d == HOLD;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_sha256_pad_1024.sv
// tb_sha256_pad_1024: directed checks of padding, latency, backpressure, length handling and reset
module tb_sha256_pad_1024;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] in_w = '0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [1:0] in_bytes = '0;
  logic in_ready, out_valid, err;
  logic [1023:0] out_w;
  logic [7:0] msg [0:127];
  int tests = 0, fails = 0, errs = 0;
  always #5 clk = ~clk;
  sha256_pad_1024 dut (
    .clk_i(clk), .rst_i(rst), .in(in_w), .in_valid(in_valid), .in_last(in_last),
    .in_bytes(in_bytes), .in_ready(in_ready), .out(out_w), .out_valid(out_valid),
    .out_ready(out_ready), .err_o(err)
  );
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish before 300000");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input int len, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < 128; i++) msg[i] = (i < len) ? 8'(int'(base) + int'(step) * i) : 8'hFF;
  endtask
  function automatic logic [1023:0] model(input int len);
    logic [1023:0] e = '0;
    for (int i = 0; i < len && i < 120; i++) e[1023-8*i -: 8] = msg[i];
    if (len < 120) e[1023-8*len -: 8] = 8'h80;
    e[63:0] = 64'(8 * len);
    return e;
  endfunction
  task automatic send_msg(input int len, input int max_words);
    int nw = (len + 3) / 4;
    for (int w = 0; w < nw && w < max_words; w++) begin
      int wc = 0;
      in_w = {msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]};
      in_last = (w == nw - 1);
      in_bytes = in_last ? 2'(len % 4) : 2'd1;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && wc < 20) begin
        tick();
        wc++;
      end
      if (in_ready !== 1'b1) begin
        tests++;
        fails++;
        $display("FAIL send_timeout word %0d: in_ready=%b, required 1", w, in_ready);
        in_valid = 1'b0;
        in_last = 1'b0;
        return;
      end
      tick();
      if (err === 1'b1) errs++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, required 0", err); end
    tests++; if (out_w !== '0) begin fails++; $display("FAIL reset_out: got %h, required 0", out_w); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b, required 1", in_ready); end
  endtask
  task automatic test_64();
    fill(64, 8'h61, 8'h00);
    send_msg(64, 99);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL m64_latency: out_valid=%b, required 1", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL m64_hold_ready: got %b, required 0", in_ready); end
    tests++; if (out_w[1023:512] !== {16{32'h61616161}}) begin fails++; $display("FAIL m64_data: got %h, required all 61", out_w[1023:512]); end
    tests++; if (out_w[511:504] !== 8'h80) begin fails++; $display("FAIL m64_marker: got %h, required 80", out_w[511:504]); end
    tests++; if (out_w[63:0] !== 64'h200) begin fails++; $display("FAIL m64_len: got %h, required 200", out_w[63:0]); end
    tests++; if (out_w !== model(64)) begin fails++; $display("FAIL m64_block: got %h, required %h", out_w, model(64)); end
    consume();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL m64_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready); end
  endtask
  task automatic test_56();
    fill(56, 8'h10, 8'h03);
    send_msg(56, 99);
    tests++; if (out_w[575:568] !== 8'h80) begin fails++; $display("FAIL m56_marker: got %h, required 80", out_w[575:568]); end
    tests++; if (out_w[63:0] !== 64'h1C0) begin fails++; $display("FAIL m56_len: got %h, required 1c0", out_w[63:0]); end
    tests++; if (out_w[567:64] !== '0) begin fails++; $display("FAIL m56_zero: got %h, required 0", out_w[567:64]); end
    tests++; if (out_w !== model(56)) begin fails++; $display("FAIL m56_block: got %h, required %h", out_w, model(56)); end
    consume();
  endtask
  task automatic test_119();
    fill(119, 8'h01, 8'h01);
    send_msg(119, 99);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL m119_valid: got %b, required 1", out_valid); end
    tests++; if (out_w[71:64] !== 8'h80) begin fails++; $display("FAIL m119_marker: got %h, required 80", out_w[71:64]); end
    tests++; if (out_w[79:72] !== 8'h77) begin fails++; $display("FAIL m119_lastbyte: got %h, required 77", out_w[79:72]); end
    tests++; if (out_w[63:0] !== 64'h3B8) begin fails++; $display("FAIL m119_len: got %h, required 3b8", out_w[63:0]); end
    tests++; if (out_w !== model(119)) begin fails++; $display("FAIL m119_block: got %h, required %h", out_w, model(119)); end
    consume();
  endtask
  task automatic test_backpressure();
    int bad = 0;
    fill(60, 8'hA5, 8'h11);
    send_msg(60, 99);
    in_w = 32'hDEADBEEF;
    in_last = 1'b1;
    in_bytes = 2'd2;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_w !== model(60) || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL bp_stable: %0d unstable cycles, required 0", bad); end
    in_valid = 1'b0;
    in_last = 1'b0;
    consume();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_accum: in_ready=%b, required 1", in_ready); end
    fill(57, 8'h3C, 8'h05);
    send_msg(57, 99);
    tests++; if (out_w !== model(57)) begin fails++; $display("FAIL bp_second: got %h, required %h", out_w, model(57)); end
    consume();
  endtask
  task automatic test_length();
`ifdef SHA256_PAD_ERR_EN
    int vbad = 0;
    fill(20, 8'h55, 8'h01);
    errs = 0;
    send_msg(20, 99);
    tests++; if (err !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL short_err: err=%b out_valid=%b, required 1 0", err, out_valid); end
    tick();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL short_pulse: err=%b, required 0", err); end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid !== 1'b0) vbad++;
    end
    tests++; if (vbad != 0) begin fails++; $display("FAIL short_novalid: %0d valid cycles, required 0", vbad); end
    fill(124, 8'h20, 8'h01);
    errs = 0;
    send_msg(124, 99);
    tests++; if (errs != 1) begin fails++; $display("FAIL long_err_count: got %0d, required 1", errs); end
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL long_drop_exit: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready); end
    fill(64, 8'h40, 8'h02);
    send_msg(64, 99);
    tests++; if (out_w !== model(64)) begin fails++; $display("FAIL after_drop_block: got %h, required %h", out_w, model(64)); end
    consume();
`else
    fill(20, 8'h55, 8'h01);
    send_msg(20, 99);
    tests++; if (out_valid !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL short_valid: out_valid=%b err=%b, required 1 0", out_valid, err); end
    tests++; if (out_w[63:0] !== 64'hA0) begin fails++; $display("FAIL short_len: got %h, required a0", out_w[63:0]); end
    tests++; if (out_w !== model(20)) begin fails++; $display("FAIL short_block: got %h, required %h", out_w, model(20)); end
    consume();
`endif
  endtask
  task automatic test_reset_mid();
    fill(64, 8'h77, 8'h03);
    send_msg(64, 7);
    rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_novalid: got %b, required 0", out_valid); end
    fill(64, 8'h90, 8'h07);
    send_msg(64, 99);
    tests++; if (out_w !== model(64)) begin fails++; $display("FAIL rst_mid_fresh: got %h, required %h", out_w, model(64)); end
    consume();
  endtask
  initial begin
    test_reset();
    test_64();
    test_56();
    test_119();
    test_backpressure();
    test_length();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
